datapath_fsm: RTL

DATAPATH_FSM -- requirements
Module: datapath_fsm

---
 rtl/datapath_fsm.sv | 128 ++++++++++++
 1 files changed

// File: rtl/datapath_fsm.sv
// Multi-cycle register-file datapath: read A, read B, execute through shifter+ALU, write back.
// Immediate ops skip straight to writeback and leave A/B/C/status untouched.
module datapath_fsm #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic [1:0]       ALUop,
  input  logic [1:0]       shift,
  input  logic             a_zero,
  input  logic             imm_en,
  input  logic [WIDTH-1:0] imm,
  input  logic             wb_en,
  input  logic             flags_en,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] datapath_out,
  output logic [2:0]       status
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXE, WB} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic [RW-1:0]    rd_q, rn_q, rm_q;
  logic [1:0]       op_q, sh_q;
  logic             az_q, imm_en_q, wb_q, fl_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] ain, bin, res;
  logic             v_flag;

  assign ready        = (state == IDLE);
  assign datapath_out = c_reg;

  always_comb begin
    ain    = az_q ? '0 : a_reg;
    bin    = b_reg;
    res    = '0;
    v_flag = 1'b0;
    case (sh_q)
      2'b01:   bin = {b_reg[WIDTH-2:0], 1'b0};
      2'b10:   bin = {1'b0, b_reg[WIDTH-1:1]};
      2'b11:   bin = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
      default: bin = b_reg;
    endcase
    case (op_q)
      2'b00: begin
        res    = ain + bin;
        v_flag = (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b01: begin
        res    = ain - bin;
        v_flag = (ain[WIDTH-1] != bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b10:   res = ain & bin;
      default: res = ~bin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
      status   <= '0;
      state    <= IDLE;
      done     <= 1'b0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      op_q     <= '0;
      sh_q     <= '0;
      az_q     <= 1'b0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      wb_q     <= 1'b0;
      fl_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rd_q     <= rd;
          rn_q     <= rn;
          rm_q     <= rm;
          op_q     <= ALUop;
          sh_q     <= shift;
          az_q     <= a_zero;
          imm_en_q <= imm_en;
          imm_q    <= imm;
          wb_q     <= wb_en;
          fl_q     <= flags_en;
          state    <= imm_en ? WB : RDA;
        end
        RDA: begin
          a_reg <= regs[rn_q];
          state <= RDB;
        end
        RDB: begin
          b_reg <= regs[rm_q];
          state <= EXE;
        end
        EXE: begin
          c_reg <= res;
          if (fl_q) status <= {res[WIDTH-1], v_flag, (res == '0)};
          state <= WB;
        end
        WB: begin
          // Immediate writes ignore wb_en; register ops write C only when enabled.
          if (imm_en_q)  regs[rd_q] <= imm_q;
          else if (wb_q) regs[rd_q] <= c_reg;
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
